// File: rtl/riscv_wb_if.sv
// riscv_wb_if: MEM-stage register outputs, data-memory response and write-back outputs.
interface riscv_wb_if #(
    parameter int XLEN           = 32,
    parameter int ILEN           = 32,
    parameter int EXCEPTION_SIZE = 16
);
    logic [XLEN-1:0]           mem_pc;
    logic [ILEN-1:0]           mem_instr;
    logic                      mem_bubble;
    logic [EXCEPTION_SIZE-1:0] mem_exception;
    logic [XLEN-1:0]           mem_r;
    logic [XLEN-1:0]           mem_memadr;
    logic [XLEN-1:0]           dmem_q;
    logic                      dmem_ack;
    logic                      dmem_err;
    logic                      wb_stall;
    logic [XLEN-1:0]           wb_pc;
    logic [ILEN-1:0]           wb_instr;
    logic                      wb_bubble;
    logic [EXCEPTION_SIZE-1:0] wb_exception;
    logic [XLEN-1:0]           wb_badaddr;
    logic                      wb_we;
    logic [4:0]                wb_dst;
    logic [XLEN-1:0]           wb_r;
    modport slave (
        input  mem_pc, mem_instr, mem_bubble, mem_exception, mem_r, mem_memadr,
               dmem_q, dmem_ack, dmem_err,
        output wb_stall, wb_pc, wb_instr, wb_bubble, wb_exception, wb_badaddr,
               wb_we, wb_dst, wb_r
    );
    modport master (
        output mem_pc, mem_instr, mem_bubble, mem_exception, mem_r, mem_memadr,
               dmem_q, dmem_ack, dmem_err,
        input  wb_stall, wb_pc, wb_instr, wb_bubble, wb_exception, wb_badaddr,
               wb_we, wb_dst, wb_r
    );
endinterface

// File: rtl/riscv_wb.sv
// riscv_wb: write-back stage; waits for data-memory completion, aligns loads,
// turns bus errors/timeouts into access faults and drives the register-file write port.
module riscv_wb #(
    parameter int              XLEN           = 32,
    parameter int              ILEN           = 32,
    parameter int              EXCEPTION_SIZE = 16,
    parameter logic [XLEN-1:0] PC_INIT        = 'h200,
    parameter int              TIMEOUT        = 16
) (
    input logic       clk,
    input logic       rstn,
    riscv_wb_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam int         CW        = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                    r_state, w_next;
    logic [CW-1:0]             r_cnt;
    logic [XLEN-1:0]           r_pc, r_badaddr, r_r;
    logic [ILEN-1:0]           r_instr;
    logic                      r_bubble, r_we;
    logic [EXCEPTION_SIZE-1:0] r_exception;
    logic [4:0]                r_dst;

    logic [6:0]                w_opcode;
    logic [2:0]                w_f3;
    logic [4:0]                w_rd;
    logic                      w_killed, w_live, w_load, w_store, w_mem_op, w_timeout;
    logic                      w_stall, w_fault, w_exc_in, w_writes;
    logic [EXCEPTION_SIZE-1:0] w_fault_bits;
    logic [XLEN-1:0]           w_shift, w_load_data;
    logic [15:0]               w_half;

    always_comb begin
        w_opcode  = bus.mem_instr[6:0];
        w_f3      = bus.mem_instr[14:12];
        w_rd      = bus.mem_instr[11:7];
        w_killed  = |r_exception;
        w_live    = !bus.mem_bubble && !w_killed && (bus.mem_exception == '0);
        w_load    = w_opcode == OP_LOAD;
        w_store   = w_opcode == OP_STORE;
        w_mem_op  = w_live && (w_load || w_store);
        w_timeout = r_cnt == CW'(TIMEOUT);
        w_stall   = w_mem_op && !bus.dmem_ack && !bus.dmem_err && !w_timeout;
        w_fault   = w_mem_op && (bus.dmem_err || w_timeout);
        w_exc_in  = !w_killed && (bus.mem_exception != '0);
        w_fault_bits    = '0;
        w_fault_bits[5] = w_fault && w_load;
        w_fault_bits[7] = w_fault && w_store;
        w_writes  = w_load || w_opcode == OP_OP || w_opcode == OP_IMM || w_opcode == OP_LUI ||
                    w_opcode == OP_AUIPC || w_opcode == OP_JAL || w_opcode == OP_JALR ||
                    (w_opcode == OP_SYSTEM && w_f3 != 3'b000);
    end

    // byte/halfword lane selection from the low address bits
    always_comb begin
        w_shift     = bus.dmem_q >> {bus.mem_memadr[1:0], 3'b000};
        w_half      = bus.mem_memadr[1] ? bus.dmem_q[31:16] : bus.dmem_q[15:0];
        w_load_data = (w_f3 == 3'b000) ? {{(XLEN-8){w_shift[7]}}, w_shift[7:0]} :
                      (w_f3 == 3'b100) ? {{(XLEN-8){1'b0}}, w_shift[7:0]} :
                      (w_f3 == 3'b001) ? {{(XLEN-16){w_half[15]}}, w_half} :
                      (w_f3 == 3'b101) ? {{(XLEN-16){1'b0}}, w_half} :
                      bus.dmem_q;
    end

    always_comb begin
        w_next = (r_state == WAIT) ? ((bus.dmem_ack || bus.dmem_err || w_timeout || !w_mem_op) ? IDLE : WAIT)
                                   : (w_stall ? WAIT : IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next == WAIT) ? r_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc        <= PC_INIT;
            r_instr     <= '0;
            r_bubble    <= 1'b1;
            r_exception <= '0;
            r_badaddr   <= '0;
            r_we        <= 1'b0;
            r_dst       <= '0;
            r_r         <= '0;
        end else if (w_stall) begin
            r_bubble    <= 1'b1;
            r_we        <= 1'b0;
            r_exception <= '0;
        end else begin
            r_pc        <= bus.mem_pc;
            r_instr     <= bus.mem_instr;
            r_dst       <= w_rd;
            r_r         <= w_load ? w_load_data : bus.mem_r;
            r_bubble    <= !(w_live || w_exc_in);
            r_exception <= w_killed ? '0 : (bus.mem_exception | w_fault_bits);
            r_we        <= w_live && w_writes && (w_rd != 5'd0) && !w_fault;
            if (w_fault || w_exc_in)
                r_badaddr <= bus.mem_memadr;
        end
    end

    assign bus.wb_stall     = w_stall;
    assign bus.wb_pc        = r_pc;
    assign bus.wb_instr     = r_instr;
    assign bus.wb_bubble    = r_bubble;
    assign bus.wb_exception = r_exception;
    assign bus.wb_badaddr   = r_badaddr;
    assign bus.wb_we        = r_we;
    assign bus.wb_dst       = r_dst;
    assign bus.wb_r         = r_r;
endmodule

// File: tb/tb_riscv_wb.sv
// tb_riscv_wb: directed sequence for riscv_wb; expected retirements are queued when driven
// and compared when the stage produces them.
module tb_riscv_wb;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] LW5     = 32'h00002283;
    localparam logic [31:0] LB6     = 32'h00000303;
    localparam logic [31:0] LBU6    = 32'h00004303;
    localparam logic [31:0] LH6     = 32'h00001303;
    localparam logic [31:0] SW0     = 32'h00002023;
    localparam logic [31:0] ADDI0   = 32'h00000013;
    localparam logic [31:0] ADDI7   = 32'h00000393;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    riscv_wb_if bus ();
    riscv_wb #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct {
        logic        bub;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] r;
        logic [15:0] exc;
        logic [31:0] bad;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic bub, input logic we, input logic [4:0] dst,
                                input logic [31:0] r, input logic [15:0] exc,
                                input logic [31:0] bad, input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.bub = bub; e.we = we; e.dst = dst; e.r = r;
        e.exc = exc; e.bad = bad; e.pc = pc; e.instr = instr;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic retire;
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("wb_bubble", bus.wb_bubble, e.bub);
            chk("wb_we", bus.wb_we, e.we);
            chk("wb_dst", bus.wb_dst, e.dst);
            chk("wb_r", bus.wb_r, e.r);
            chk("wb_exception", bus.wb_exception, e.exc);
            chk("wb_badaddr", bus.wb_badaddr, e.bad);
            chk("wb_pc", bus.wb_pc, e.pc);
            chk("wb_instr", bus.wb_instr, e.instr);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] r,
                         input logic [31:0] adr, input logic [31:0] q, input logic [15:0] exc,
                         input logic bub);
        bus.mem_pc        = pc;
        bus.mem_instr     = instr;
        bus.mem_r         = r;
        bus.mem_memadr    = adr;
        bus.dmem_q        = q;
        bus.mem_exception = exc;
        bus.mem_bubble    = bub;
        bus.dmem_ack      = 1'b0;
        bus.dmem_err      = 1'b0;
    endtask

    // waits: stall cycles expected before the response (ack/err) is presented
    task automatic run(input int waits, input logic ack, input logic err, input exp_t e);
        for (int i = 0; i < waits; i++) begin
            #1 chk("stall_hi", bus.wb_stall, 1'b1);
            tick();
            chk("stall_bubble", bus.wb_bubble, 1'b1);
            chk("stall_we", bus.wb_we, 1'b0);
            chk("stall_exc", bus.wb_exception, 16'h0);
        end
        bus.dmem_ack = ack;
        bus.dmem_err = err;
        #1 chk("stall_lo", bus.wb_stall, 1'b0);
        sb.push_back(e);
        tick();
        retire();
        bus.dmem_ack = 1'b0;
        bus.dmem_err = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 1'b1);
        tick();
        tick();
        chk("rst_stall", bus.wb_stall, 1'b0);
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 32'h200, 0));
        retire();
        rstn = 1'b1;

        drive(32'h100, LW5, 0, 32'h1000, 32'hDEADBEEF, 0, 0);
        run(0, 1, 0, mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h100, LW5));
        drive(32'h104, LB6, 0, 32'h1003, 32'h80123456, 0, 0);
        run(0, 1, 0, mk(0, 1, 6, 32'hFFFFFF80, 0, 0, 32'h104, LB6));
        drive(32'h108, LBU6, 0, 32'h1003, 32'h80123456, 0, 0);
        run(0, 1, 0, mk(0, 1, 6, 32'h00000080, 0, 0, 32'h108, LBU6));
        drive(32'h10C, LH6, 0, 32'h1002, 32'h80015678, 0, 0);
        run(0, 1, 0, mk(0, 1, 6, 32'hFFFF8001, 0, 0, 32'h10C, LH6));

        drive(32'h110, SW0, 32'h55, 32'h2000, 0, 0, 0);
        run(3, 1, 0, mk(0, 0, 0, 32'h55, 0, 0, 32'h110, SW0));

        drive(32'h114, LW5, 0, 32'h3000, 32'h11111111, 0, 0);
        run(TIMEOUT, 0, 0, mk(0, 0, 5, 32'h11111111, 16'h0020, 32'h3000, 32'h114, LW5));
        drive(32'h118, ADDI7, 32'h1234, 0, 0, 0, 0);
        run(0, 0, 0, mk(1, 0, 7, 32'h1234, 0, 32'h3000, 32'h118, ADDI7));

        drive(32'h11C, SW0, 32'h77, 32'h4000, 0, 0, 0);
        run(2, 0, 1, mk(0, 0, 0, 32'h77, 16'h0080, 32'h4000, 32'h11C, SW0));
        drive(32'h124, 0, 0, 0, 0, 0, 1);
        run(0, 0, 0, mk(1, 0, 0, 0, 0, 32'h4000, 32'h124, 0));
        drive(32'h128, ADDI0, 32'h99, 0, 0, 0, 0);
        run(0, 0, 0, mk(0, 0, 0, 32'h99, 0, 32'h4000, 32'h128, ADDI0));
        drive(32'h12C, ADDI7, 32'h1234, 0, 0, 0, 0);
        run(0, 0, 0, mk(0, 1, 7, 32'h1234, 0, 32'h4000, 32'h12C, ADDI7));

        drive(32'h130, LW5, 0, 32'h5000, 0, 16'h0004, 0);
        run(0, 0, 0, mk(0, 0, 5, 0, 16'h0004, 32'h5000, 32'h130, LW5));
        drive(32'h134, ADDI7, 32'h1, 0, 0, 0, 0);
        run(0, 0, 0, mk(1, 0, 7, 32'h1, 0, 32'h5000, 32'h134, ADDI7));

        drive(32'h138, LW5, 0, 32'h6000, 32'hCAFEF00D, 0, 0);
        run(0, 1, 1, mk(0, 0, 5, 32'hCAFEF00D, 16'h0020, 32'h6000, 32'h138, LW5));
        drive(32'h13C, LW5, 0, 32'h7000, 32'h5, 0, 0);
        run(0, 1, 0, mk(1, 0, 5, 32'h5, 0, 32'h6000, 32'h13C, LW5));

        drive(32'h140, SW0, 0, 32'h8000, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("rw_stall_hi", bus.wb_stall, 1'b1);
            tick();
        end
        rstn = 1'b0;
        bus.mem_bubble = 1'b1;
        #1 chk("rw_stall_bubble", bus.wb_stall, 1'b0);
        tick();
        sb.push_back(mk(1, 0, 0, 0, 0, 0, 32'h200, 0));
        retire();
        rstn = 1'b1;
        bus.mem_bubble = 1'b0;
        run(TIMEOUT, 0, 0, mk(0, 0, 0, 0, 16'h0080, 32'h8000, 32'h140, SW0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
